// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the polar-to-rectangular CORDIC rotation engine:
//   - default parameter values for the engine and its bus interface
//   - prescale gain constant (1/K of the CORDIC gain, Q12)
//   - arctangent table in binary-angle units with two fractional bits
//   - controller state encoding
//   - generic signed saturation helper
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam int DEF_MAX_WIDTH  = 13;
    localparam int DEF_CADC_WIDTH = 10;
    localparam int DEF_ANG_WIDTH  = 13;
    localparam int DEF_ITER       = 12;

    // Fractional guard bits carried on x/y through the micro-rotations.
    localparam int GUARD = 2;

    // Inverse CORDIC gain 0.60725 in Q12.
    localparam int          K_SHIFT = 12;
    localparam logic [31:0] K_Q     = 32'd2487;

    // Half of one output LSB expressed in guard units, used for rounding.
    localparam logic signed [31:0] ROUND_HALF = 32'sd1 <<< (GUARD - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESCALE = 3'd1,
        ST_ITER     = 3'd2,
        ST_OUTPUT   = 3'd3,
        ST_DONE     = 3'd4
    } cordic_state_e;

    // atan(2^-i) scaled so that a full circle is 2^(ANG_WIDTH+2) for the
    // default 13-bit angle, i.e. the binary angle with two fractional bits.
    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'd4096;
            4'd1:    val = 16'd2418;
            4'd2:    val = 16'd1278;
            4'd3:    val = 16'd649;
            4'd4:    val = 16'd326;
            4'd5:    val = 16'd163;
            4'd6:    val = 16'd81;
            4'd7:    val = 16'd41;
            4'd8:    val = 16'd20;
            4'd9:    val = 16'd10;
            4'd10:   val = 16'd5;
            4'd11:   val = 16'd3;
            4'd12:   val = 16'd1;
            4'd13:   val = 16'd1;
            4'd14:   val = 16'd0;
            4'd15:   val = 16'd0;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

    // Clamp a signed value into the range of a signed field of 'width' bits.
    // The caller truncates the result to that width.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] res;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/cordic_polar2rect_if.sv
// -----------------------------------------------------------------------------
// cordic_polar2rect_if
// Request/result bundle of the polar-to-rectangular CORDIC engine.
//   enable             level start (rising edge starts, low mid-run aborts)
//   R_IN               unsigned magnitude, MAX_WIDTH-1 bits
//   ANG_IN             unsigned binary angle, full circle = 2^ANG_WIDTH
//   OFFSET             unsigned bias added to both outputs
//   X_OUT / Y_OUT      signed saturated R*cos + OFFSET / R*sin + OFFSET
//   cordic_rot_is_done result valid, held until next start/abort/reset
// master: the requester (drives request fields); slave: the engine.
// -----------------------------------------------------------------------------
interface cordic_polar2rect_if
    import cordic_pkg::*;
#(
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int CADC_WIDTH = DEF_CADC_WIDTH,
    parameter int ANG_WIDTH  = DEF_ANG_WIDTH
);
    logic                        enable;
    logic        [MAX_WIDTH-2:0] R_IN;
    logic        [ANG_WIDTH-1:0] ANG_IN;
    logic       [CADC_WIDTH-1:0] OFFSET;
    logic signed [MAX_WIDTH-1:0] X_OUT;
    logic signed [MAX_WIDTH-1:0] Y_OUT;
    logic                        cordic_rot_is_done;

    modport master (
        output enable, R_IN, ANG_IN, OFFSET,
        input  X_OUT, Y_OUT, cordic_rot_is_done
    );

    modport slave (
        input  enable, R_IN, ANG_IN, OFFSET,
        output X_OUT, Y_OUT, cordic_rot_is_done
    );

endinterface

// File: rtl/cordic_rot_stage.sv
// -----------------------------------------------------------------------------
// cordic_rot_stage
// One combinational CORDIC rotation-mode micro-rotation.
//   x, y, z         current vector and residual angle
//   idx             iteration index i (shift amount and table index)
//   x_next, y_next  rotated vector
//   z_next          updated residual angle
// Direction is +1 when the residual angle is non-negative, else -1.
// -----------------------------------------------------------------------------
module cordic_rot_stage
    import cordic_pkg::*;
#(
    parameter int XW = 16,
    parameter int ZW = 16
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic signed [ZW-1:0] z,
    input  logic        [3:0]    idx,
    output logic signed [XW-1:0] x_next,
    output logic signed [XW-1:0] y_next,
    output logic signed [ZW-1:0] z_next
);

    logic signed [XW-1:0] x_shift_s;
    logic signed [XW-1:0] y_shift_s;
    logic signed [ZW-1:0] atan_s;

    // Single micro-rotation: arithmetic shifts keep the sign of negative coordinates.
    always_comb begin
        x_shift_s = x >>> idx;
        y_shift_s = y >>> idx;
        atan_s    = ZW'(atan_lut(idx));
        if (z[ZW-1] == 1'b0) begin
            x_next = x - y_shift_s;
            y_next = y + x_shift_s;
            z_next = z - atan_s;
        end else begin
            x_next = x + y_shift_s;
            y_next = y - x_shift_s;
            z_next = z + atan_s;
        end
    end

endmodule

// File: rtl/cordic_polar2rect.sv
// -----------------------------------------------------------------------------
// cordic_polar2rect
// Iterative CORDIC rotation engine: (R, angle) -> (R*cos + OFFSET,
// R*sin + OFFSET), one micro-rotation per clock, enable/done handshake.
//   CLK    clock
//   RST_N  synchronous active-low reset
//   bus    cordic_polar2rect_if.slave (enable, R_IN, ANG_IN, OFFSET in;
//          X_OUT, Y_OUT, cordic_rot_is_done out)
// Result appears ITER+2 clocks after the start edge:
//   PRESCALE (1) -> ITER micro-rotations -> OUTPUT (1) -> DONE.
// -----------------------------------------------------------------------------
module cordic_polar2rect
    import cordic_pkg::*;
#(
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int CADC_WIDTH = DEF_CADC_WIDTH,
    parameter int ANG_WIDTH  = DEF_ANG_WIDTH,
    parameter int ITER       = DEF_ITER
) (
    input logic                CLK,
    input logic                RST_N,
    cordic_polar2rect_if.slave bus
);

    localparam int         XW        = MAX_WIDTH + 3;
    localparam int         ZW        = ANG_WIDTH + 3;
    localparam logic [3:0] ITER_LAST = 4'(ITER - 1);

    cordic_state_e               state_r;
    logic                        enable_q_r;
    logic        [MAX_WIDTH-2:0] r_lat_r;
    logic        [ANG_WIDTH-1:0] ang_lat_r;
    logic       [CADC_WIDTH-1:0] offset_r;
    logic signed        [XW-1:0] x_r;
    logic signed        [XW-1:0] y_r;
    logic signed        [ZW-1:0] z_r;
    logic                  [3:0] iter_r;
    logic signed [MAX_WIDTH-1:0] x_out_r;
    logic signed [MAX_WIDTH-1:0] y_out_r;
    logic                        done_r;

    logic                        start_s;
    logic signed        [XW-1:0] rk_s;
    logic signed        [XW-1:0] x_init_s;
    logic signed        [XW-1:0] y_init_s;
    logic signed        [ZW-1:0] z_init_s;
    logic signed        [XW-1:0] x_next_s;
    logic signed        [XW-1:0] y_next_s;
    logic signed        [ZW-1:0] z_next_s;
    logic signed          [31:0] x_wide_s;
    logic signed          [31:0] y_wide_s;
    logic signed          [31:0] offset_wide_s;
    logic signed          [31:0] x_sum_s;
    logic signed          [31:0] y_sum_s;

    assign start_s = bus.enable & ~enable_q_r;

    cordic_rot_stage #(
        .XW(XW),
        .ZW(ZW)
    ) u_stage (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .idx    (iter_r),
        .x_next (x_next_s),
        .y_next (y_next_s),
        .z_next (z_next_s)
    );

    // Gain prescale and quadrant fold of the latched request.
    // Rk keeps GUARD fractional bits so the shift is K_SHIFT-GUARD, not K_SHIFT.
    always_comb begin
        rk_s = XW'((32'(r_lat_r) * K_Q) >> (K_SHIFT - GUARD));
        case (ang_lat_r[ANG_WIDTH-1 -: 2])
            2'd0: begin
                x_init_s = rk_s;
                y_init_s = '0;
            end
            2'd1: begin
                x_init_s = '0;
                y_init_s = rk_s;
            end
            2'd2: begin
                x_init_s = -rk_s;
                y_init_s = '0;
            end
            2'd3: begin
                x_init_s = '0;
                y_init_s = -rk_s;
            end
            default: begin
                x_init_s = '0;
                y_init_s = '0;
            end
        endcase
        // Residual angle inside the quadrant, with two fractional zero bits.
        z_init_s = ZW'({ang_lat_r[ANG_WIDTH-3:0], 2'b00});
    end

    // Round away the guard bits and add the bias, in a wide signed domain.
    always_comb begin
        x_wide_s      = $signed({{(32 - XW){x_r[XW-1]}}, x_r});
        y_wide_s      = $signed({{(32 - XW){y_r[XW-1]}}, y_r});
        offset_wide_s = $signed({{(32 - CADC_WIDTH){1'b0}}, offset_r});
        x_sum_s       = ((x_wide_s + ROUND_HALF) >>> GUARD) + offset_wide_s;
        y_sum_s       = ((y_wide_s + ROUND_HALF) >>> GUARD) + offset_wide_s;
    end

    // Controller and datapath registers; an enable low while busy aborts.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            enable_q_r <= 1'b0;
            r_lat_r    <= '0;
            ang_lat_r  <= '0;
            offset_r   <= '0;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
            iter_r     <= 4'd0;
            x_out_r    <= '0;
            y_out_r    <= '0;
            done_r     <= 1'b0;
        end else begin
            enable_q_r <= bus.enable;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        r_lat_r   <= bus.R_IN;
                        ang_lat_r <= bus.ANG_IN;
                        offset_r  <= bus.OFFSET;
                        done_r    <= 1'b0;
                        state_r   <= ST_PRESCALE;
                    end
                end
                ST_PRESCALE: begin
                    if (!bus.enable) begin
                        state_r <= ST_IDLE;
                    end else begin
                        x_r     <= x_init_s;
                        y_r     <= y_init_s;
                        z_r     <= z_init_s;
                        iter_r  <= 4'd0;
                        state_r <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (!bus.enable) begin
                        state_r <= ST_IDLE;
                    end else begin
                        x_r <= x_next_s;
                        y_r <= y_next_s;
                        z_r <= z_next_s;
                        if (iter_r == ITER_LAST) begin
                            state_r <= ST_OUTPUT;
                        end else begin
                            iter_r <= iter_r + 4'd1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (!bus.enable) begin
                        state_r <= ST_IDLE;
                    end else begin
                        x_out_r <= MAX_WIDTH'(sat_signed(x_sum_s, MAX_WIDTH));
                        y_out_r <= MAX_WIDTH'(sat_signed(y_sum_s, MAX_WIDTH));
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.X_OUT              = x_out_r;
    assign bus.Y_OUT              = y_out_r;
    assign bus.cordic_rot_is_done = done_r;

endmodule

// File: tb/tb_cordic_polar2rect.sv
// -----------------------------------------------------------------------------
// tb_cordic_polar2rect
// Self-checking bench for cordic_polar2rect. Expected outputs come from an
// ideal floating-point polar-to-rectangular model (round, add bias, clamp).
// -----------------------------------------------------------------------------
module tb_cordic_polar2rect;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    cordic_polar2rect_if bus ();

    cordic_polar2rect dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    localparam int LATENCY = 14;
    localparam int TOL     = 3;

    // Ideal R*cos/sin(theta) + OFFSET, rounded, clamped to signed 13 bits.
    function automatic int ideal(input int r, input int ang, input int off, input bit is_y);
        real th;
        real v;
        int  iv;
        th = real'(ang) * 6.283185307179586 / 8192.0;
        v  = real'(r) * (is_y ? $sin(th) : $cos(th)) + real'(off);
        iv = int'(v);
        if (iv > 4095)  iv = 4095;
        if (iv < -4096) iv = -4096;
        return iv;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Issue one conversion, scramble the inputs after the start edge, and
    // report the edge count at which done rose (-1 if it never did).
    task automatic run_conv(input int r, input int ang, input int off,
                            output int lat, output int xo, output int yo,
                            output logic done_at_start);
        @(negedge CLK);
        bus.enable = 1'b0;
        @(negedge CLK);
        bus.R_IN   = 12'(r);
        bus.ANG_IN = 13'(ang);
        bus.OFFSET = 10'(off);
        bus.enable = 1'b1;
        @(posedge CLK);
        #1;
        done_at_start = bus.cordic_rot_is_done;
        bus.R_IN   = 12'($urandom);
        bus.ANG_IN = 13'($urandom);
        bus.OFFSET = 10'($urandom);
        lat = -1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge CLK);
            #1;
            if (bus.cordic_rot_is_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        xo = int'(bus.X_OUT);
        yo = int'(bus.Y_OUT);
    endtask

    task automatic test_reset();
        RST_N      = 1'b0;
        bus.enable = 1'b0;
        bus.R_IN   = 12'd0;
        bus.ANG_IN = 13'd0;
        bus.OFFSET = 10'd0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus.X_OUT !== 13'sd0) begin
            n_errors++;
            $display("FAIL reset_x: got %0d want 0", bus.X_OUT);
        end
        n_checks++;
        if (bus.Y_OUT !== 13'sd0) begin
            n_errors++;
            $display("FAIL reset_y: got %0d want 0", bus.Y_OUT);
        end
        n_checks++;
        if (bus.cordic_rot_is_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_done: got %b want 0", bus.cordic_rot_is_done);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_directed();
        int   tr [6] = '{1000, 1000, 1000, 612, 0,    4095};
        int   ta [6] = '{0,    2048, 5461, 0,   1234, 0};
        int   to [6] = '{0,    0,    0,    512, 512,  1023};
        int   lat, xo, yo, ex, ey, tol;
        logic ds;
        for (int i = 0; i < 6; i++) begin
            run_conv(tr[i], ta[i], to[i], lat, xo, yo, ds);
            ex  = ideal(tr[i], ta[i], to[i], 1'b0);
            ey  = ideal(tr[i], ta[i], to[i], 1'b1);
            tol = (tr[i] == 0) ? 0 : TOL;
            n_checks++;
            if (lat !== LATENCY) begin
                n_errors++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LATENCY);
            end
            n_checks++;
            if (iabs(xo - ex) > tol) begin
                n_errors++;
                $display("FAIL directed_x[%0d]: got %0d want %0d +-%0d", i, xo, ex, tol);
            end
            n_checks++;
            if (iabs(yo - ey) > tol) begin
                n_errors++;
                $display("FAIL directed_y[%0d]: got %0d want %0d +-%0d", i, yo, ey, tol);
            end
        end
    endtask

    task automatic test_random();
        int   r, a, o, lat, xo, yo, ex, ey;
        logic ds;
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 2000));
            a = int'($urandom_range(0, 8191));
            o = int'($urandom_range(0, 1023));
            run_conv(r, a, o, lat, xo, yo, ds);
            ex = ideal(r, a, o, 1'b0);
            ey = ideal(r, a, o, 1'b1);
            n_checks++;
            if (ds !== 1'b0) begin
                n_errors++;
                $display("FAIL random_done_clear[%0d]: got %b want 0", i, ds);
            end
            n_checks++;
            if (lat !== LATENCY) begin
                n_errors++;
                $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, LATENCY);
            end
            n_checks++;
            if (iabs(xo - ex) > TOL) begin
                n_errors++;
                $display("FAIL random_x[%0d] r=%0d a=%0d o=%0d: got %0d want %0d", i, r, a, o, xo, ex);
            end
            n_checks++;
            if (iabs(yo - ey) > TOL) begin
                n_errors++;
                $display("FAIL random_y[%0d] r=%0d a=%0d o=%0d: got %0d want %0d", i, r, a, o, yo, ey);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int   lat, xo, yo;
        logic ds;
        run_conv(1000, 2048, 0, lat, xo, yo, ds);
        @(negedge CLK);
        bus.enable = 1'b0;
        @(negedge CLK);
        bus.R_IN   = 12'd700;
        bus.ANG_IN = 13'd1000;
        bus.OFFSET = 10'd100;
        bus.enable = 1'b1;
        @(posedge CLK);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST_N      = 1'b0;
        bus.enable = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.X_OUT !== 13'sd0 || bus.Y_OUT !== 13'sd0) begin
            n_errors++;
            $display("FAIL midreset_xy: got %0d,%0d want 0,0", bus.X_OUT, bus.Y_OUT);
        end
        n_checks++;
        if (bus.cordic_rot_is_done !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_done: got %b want 0", bus.cordic_rot_is_done);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        run_conv(700, 1000, 100, lat, xo, yo, ds);
        n_checks++;
        if (lat !== LATENCY) begin
            n_errors++;
            $display("FAIL midreset_restart_latency: got %0d want %0d", lat, LATENCY);
        end
        n_checks++;
        if (iabs(xo - ideal(700, 1000, 100, 1'b0)) > TOL || iabs(yo - ideal(700, 1000, 100, 1'b1)) > TOL) begin
            n_errors++;
            $display("FAIL midreset_restart_xy: got %0d,%0d want %0d,%0d", xo, yo,
                     ideal(700, 1000, 100, 1'b0), ideal(700, 1000, 100, 1'b1));
        end
    endtask

    task automatic test_abort();
        int   lat, xo, yo;
        logic ds;
        bit   done_seen, x_moved;
        run_conv(1000, 0, 0, lat, xo, yo, ds);
        @(negedge CLK);
        bus.enable = 1'b0;
        @(negedge CLK);
        bus.R_IN   = 12'd1000;
        bus.ANG_IN = 13'd4096;
        bus.OFFSET = 10'd0;
        bus.enable = 1'b1;
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        bus.enable = 1'b0;
        done_seen = 1'b0;
        x_moved   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK);
            #1;
            if (bus.cordic_rot_is_done !== 1'b0) done_seen = 1'b1;
            if (iabs(int'(bus.X_OUT) - 1000) > TOL || iabs(int'(bus.Y_OUT)) > TOL) x_moved = 1'b1;
        end
        n_checks++;
        if (done_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_done: got done=1 after abort, want 0");
        end
        n_checks++;
        if (x_moved !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_hold: got %0d,%0d want previous 1000,0", bus.X_OUT, bus.Y_OUT);
        end
        run_conv(1000, 4096, 0, lat, xo, yo, ds);
        n_checks++;
        if (lat !== LATENCY) begin
            n_errors++;
            $display("FAIL abort_restart_latency: got %0d want %0d", lat, LATENCY);
        end
        n_checks++;
        if (iabs(xo + 1000) > TOL || iabs(yo) > TOL) begin
            n_errors++;
            $display("FAIL abort_restart_xy: got %0d,%0d want -1000,0", xo, yo);
        end
    endtask

    task automatic test_hold_high();
        int   lat, xo, yo, ex, ey;
        logic ds;
        bit   bad;
        run_conv(1500, 700, 300, lat, xo, yo, ds);
        ex  = ideal(1500, 700, 300, 1'b0);
        ey  = ideal(1500, 700, 300, 1'b1);
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK);
            #1;
            if (bus.cordic_rot_is_done !== 1'b1) bad = 1'b1;
            if (iabs(int'(bus.X_OUT) - ex) > TOL || iabs(int'(bus.Y_OUT) - ey) > TOL) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_high: got done=%b x=%0d y=%0d want 1,%0d,%0d",
                     bus.cordic_rot_is_done, bus.X_OUT, bus.Y_OUT, ex, ey);
        end
        @(negedge CLK);
        bus.enable = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus.cordic_rot_is_done !== 1'b1) begin
            n_errors++;
            $display("FAIL fall_in_done: got done=%b want 1", bus.cordic_rot_is_done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_run();
        test_abort();
        test_hold_high();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
